dd_scan_receiver: RTL

DD_SCAN_RECEIVER -- requirements
Module: dd_scan_receiver

---
 rtl/dd_scan_receiver_if.sv | 21 ++
 rtl/dd_scan_receiver.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dd_scan_receiver_if.sv
// dd_scan_receiver_if: scanned display inputs (gate/led) and the decoded frame outputs
interface dd_scan_receiver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0] gate;
    logic [7:0] led;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0] dp;
    logic [NUM_DIGITS-1:0] digit_err;
    logic frame_valid;
    logic stale;
    logic [7:0] collisions;
    modport master (
        output gate, led,
        input digits, dp, digit_err, frame_valid, stale, collisions
    );
    modport slave (
        input gate, led,
        output digits, dp, digit_err, frame_valid, stale, collisions
    );
endinterface

// File: rtl/dd_scan_receiver.sv
// dd_scan_receiver: decodes a multiplexed 7-segment scan into per-digit hex frames
// Define DD_SCAN_DP_EN to capture decimal points (led[7]); otherwise dp is 0 and led[7] is ignored.
module dd_scan_receiver #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE = 8,
    parameter int TIMEOUT = 4096
) (
    input logic clk,
    input logic rst,
    dd_scan_receiver_if.slave bus
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef DD_SCAN_DP_EN
    localparam logic [7:0] LED_MASK = 8'hFF;
`else
    localparam logic [7:0] LED_MASK = 8'h7F;
`endif
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} stateT;
    stateT state;
    logic [NUM_DIGITS-1:0] gateR, capGate, seen, pendErr, digErr;
    logic [7:0] ledR, capLed, coll;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [NUM_DIGITS-1:0][3:0] pendVal, digVal;
    logic frameValid, oneHot, multiHot, changed, accept;
    logic [IW-1:0] gateIdx;
    logic [4:0] dec;
`ifdef DD_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] pendDp, dpR;
`endif
    // {error, value}; unknown patterns decode to value 0 with error set
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: return 5'h00;
            7'h06: return 5'h01;
            7'h5B: return 5'h02;
            7'h4F: return 5'h03;
            7'h66: return 5'h04;
            7'h6D: return 5'h05;
            7'h7D: return 5'h06;
            7'h07: return 5'h07;
            7'h7F: return 5'h08;
            7'h6F: return 5'h09;
            7'h77: return 5'h0A;
            7'h7C: return 5'h0B;
            7'h39: return 5'h0C;
            7'h5E: return 5'h0D;
            7'h79: return 5'h0E;
            7'h71: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction
    always_comb begin
        oneHot = gateR != '0 && (gateR & (gateR - 1'b1)) == '0;
        multiHot = gateR != '0 && !oneHot;
        changed = gateR != capGate || ledR != capLed;
        gateIdx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) if (gateR[i]) gateIdx = IW'(i);
        dec = decode(ledR[6:0]);
        accept = oneHot && (state == ST_IDLE || changed ? SETTLE == 1 : state == ST_SETTLE && int'(cnt) + 1 >= SETTLE);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gateR <= '0;
            ledR <= '0;
            capGate <= '0;
            capLed <= '0;
            cnt <= '0;
            state <= ST_IDLE;
        end else begin
            gateR <= bus.gate;
            ledR <= bus.led & LED_MASK;
            if (!oneHot) begin
                state <= ST_IDLE;
            end else if (state == ST_IDLE || changed) begin
                state <= accept ? ST_HOLD : ST_SETTLE;
                cnt <= CW'(1);
                capGate <= gateR;
                capLed <= ledR;
            end else if (state == ST_SETTLE) begin
                state <= accept ? ST_HOLD : ST_SETTLE;
                cnt <= cnt + 1'b1;
            end
        end
    end
    // Frame copy reads the old pending buffer, so a same-cycle acceptance lands in the next frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen <= '0;
            pendVal <= '0;
            pendErr <= '0;
            digVal <= '0;
            digErr <= '0;
            frameValid <= 1'b0;
            tmo <= '0;
            coll <= '0;
`ifdef DD_SCAN_DP_EN
            pendDp <= '0;
            dpR <= '0;
`endif
        end else begin
            frameValid <= &seen;
            seen <= (seen & {NUM_DIGITS{~&seen}}) | (gateR & {NUM_DIGITS{accept}});
            if (&seen) begin
                digVal <= pendVal;
                digErr <= pendErr;
`ifdef DD_SCAN_DP_EN
                dpR <= pendDp;
`endif
            end
            if (accept) begin
                pendVal[gateIdx] <= dec[3:0];
                pendErr[gateIdx] <= dec[4];
`ifdef DD_SCAN_DP_EN
                pendDp[gateIdx] <= ledR[7];
`endif
            end
            tmo <= frameValid ? '0 : tmo + TW'(tmo != TW'(TIMEOUT));
            coll <= coll + 8'(multiHot && coll != 8'hFF);
        end
    end
    assign bus.digits = digVal;
    assign bus.digit_err = digErr;
    assign bus.frame_valid = frameValid;
    assign bus.stale = tmo == TW'(TIMEOUT);
    assign bus.collisions = coll;
`ifdef DD_SCAN_DP_EN
    assign bus.dp = dpR;
`else
    assign bus.dp = '0;
`endif
endmodule
